// File: rtl/add_sched.sv
// Round-robin scheduler sharing one pipelined adder among R requesters, with per-op tag tracking.
// Optional per-requester grant counters are built when ADD_SCHED_STATS_EN is defined.
module add_sched #(
  parameter int N   = 32,
  parameter int R   = 4,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           en,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  input  logic [N-1:0]   add_sum,
  output logic [R-1:0]   rsp_valid,
  output logic [N-1:0]   rsp_sum,
`ifdef ADD_SCHED_STATS_EN
  input  logic           stat_clr,
  output logic [R*16-1:0] stat_grants,
`endif
  output logic           busy
);

  localparam int IW = $clog2(R);
  // The output register is the last tag stage, so the pipe itself holds LAT-1 stages.
  localparam int PD = (LAT > 1) ? LAT - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [PD-1:0]        tag_vld_q, tag_vld_d;
  logic [PD-1:0][IW-1:0] tag_id_q, tag_id_d;
  logic [N-1:0]         last_a_q, last_a_d;
  logic [N-1:0]         last_b_q, last_b_d;
  logic [R-1:0]         rsp_valid_q, rsp_valid_d;
  logic [N-1:0]         rsp_sum_q, rsp_sum_d;

  logic                 grant_found;
  logic [IW-1:0]        grant_id;
  logic                 xfer;
  logic                 last_vld;
  logic [IW-1:0]        last_id;
  logic                 pipe_empty;

  function automatic logic [R-1:0] onehot(input logic [IW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // Search starts at ptr_q and wraps, giving the lowest valid index at or above the pointer.
  always_comb begin : p_arb
    int idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= R) idx = idx - R;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  // Gating with nreset keeps req_ready low while reset is held, even with requests pending.
  assign xfer      = grant_found && en && (state_q != S_DRAIN) && nreset;
  assign req_ready = xfer ? onehot(grant_id) : '0;

  always_comb begin
    last_a_d = last_a_q;
    last_b_d = last_b_q;
    if (xfer) begin
      last_a_d = req_a[grant_id*N +: N];
      last_b_d = req_b[grant_id*N +: N];
    end
  end

  assign add_a = last_a_d;
  assign add_b = last_b_d;

  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = grant_id;
    for (int i = 1; i < PD; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    if (LAT == 1) begin
      last_vld   = xfer;
      last_id    = grant_id;
      pipe_empty = 1'b1;
    end else begin
      last_vld   = tag_vld_q[PD-1];
      last_id    = tag_id_q[PD-1];
      pipe_empty = ~|tag_vld_q;
    end
  end

  always_comb begin
    rsp_valid_d = last_vld ? onehot(last_id) : '0;
    rsp_sum_d   = last_vld ? add_sum : rsp_sum_q;
    ptr_d       = ptr_q;
    if (xfer) ptr_d = (grant_id == IW'(R - 1)) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (xfer) state_d = S_BUSY;
      S_BUSY: begin
        if (!en && !pipe_empty)      state_d = S_DRAIN;
        else if (pipe_empty && !xfer) state_d = S_IDLE;
      end
      S_DRAIN: if (pipe_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      last_a_q    <= '0;
      last_b_q    <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      last_a_q    <= last_a_d;
      last_b_q    <= last_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != S_IDLE) || !pipe_empty;

`ifdef ADD_SCHED_STATS_EN
  logic [R-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < R; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr)                                 cnt_d[i] = '0;
      else if (req_ready[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stat_grants = cnt_q;
`endif

endmodule

// File: tb/tb_add_sched.sv
// Directed self-checking bench for add_sched (N=32, R=4, LAT=2) with a registered adder model.
// Stats checks are compiled in when ADD_SCHED_STATS_EN is defined.
module tb_add_sched;

  logic         clk;
  logic         nreset;
  logic         en;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_sum;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_sum;
  logic         busy;
`ifdef ADD_SCHED_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat_grants;
`endif

  int n_pass;
  int n_total;

  // Adder model: operands registered on issue, sum presented the following cycle and
  // captured by the scheduler's response register, giving the 2-cycle issue-to-response.
  logic [31:0] mdl_a_q, mdl_b_q;
  always @(posedge clk) begin
    mdl_a_q <= add_a;
    mdl_b_q <= add_b;
  end
  assign add_sum = mdl_a_q + mdl_b_q;

  add_sched #(.N(32), .R(4), .LAT(2)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .en         (en),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .rsp_valid  (rsp_valid),
    .rsp_sum    (rsp_sum),
`ifdef ADD_SCHED_STATS_EN
    .stat_clr   (stat_clr),
    .stat_grants(stat_grants),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic set_rr_ops;
    for (int i = 0; i < 4; i++) set_op(i, 32'd100 + 32'(i), 32'd10 * 32'(i));
  endtask

  task automatic do_reset;
    nreset    = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
`ifdef ADD_SCHED_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset;
    nreset    = 1'b0;
    en        = 1'b1;
    req_valid = 4'hF;
    set_rr_ops();
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else n_pass++;
    n_total++; if (rsp_sum !== 32'd0) $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); else n_pass++;
    n_total++; if (add_a !== 32'd0) $display("FAIL reset_add_a: got %h want 0", add_a); else n_pass++;
    n_total++; if (add_b !== 32'd0) $display("FAIL reset_add_b: got %h want 0", add_b); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_op;
    do_reset();
    en        = 1'b1;
    set_op(2, 32'd5, 32'd7);
    req_valid = 4'b0100;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else n_pass++;
    n_total++; if (add_a !== 32'd5) $display("FAIL single_add_a: got %0d want 5", add_a); else n_pass++;
    n_total++; if (add_b !== 32'd7) $display("FAIL single_add_b: got %0d want 7", add_b); else n_pass++;
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0000) $display("FAIL single_ready_c1: got %b want 0000", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_early: got %b want 0000", rsp_valid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy_c1: got %b want 1", busy); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); else n_pass++;
    n_total++; if (rsp_sum !== 32'd12) $display("FAIL single_rsp_sum: got %0d want 12", rsp_sum); else n_pass++;
    n_total++; if (add_a !== 32'd5) $display("FAIL single_add_a_hold: got %0d want 5", add_a); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_pulse: got %b want 0000", rsp_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [3:0]  exp_rdy;
    logic [31:0] exp_a;
    logic [3:0]  exp_rsp;
    logic [31:0] exp_sum;
    do_reset();
    en = 1'b1;
    set_rr_ops();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_total++;
      if (req_ready !== exp_rdy) $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, exp_rdy);
      else n_pass++;
      if (c < 8) begin
        exp_a = 32'd100 + 32'(c % 4);
        n_total++;
        if (add_a !== exp_a) $display("FAIL rr_add_a c%0d: got %0d want %0d", c, add_a, exp_a);
        else n_pass++;
      end
      exp_rsp = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
      n_total++;
      if (rsp_valid !== exp_rsp) $display("FAIL rr_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp);
      else n_pass++;
      if (c >= 2) begin
        exp_sum = 32'd100 + 32'd11 * 32'((c - 2) % 4);
        n_total++;
        if (rsp_sum !== exp_sum) $display("FAIL rr_rsp_sum c%0d: got %0d want %0d", c, rsp_sum, exp_sum);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap;
    do_reset();
    en = 1'b1;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0002);
    req_valid = 4'b0001;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0001) $display("FAIL wrap_ready: got %b want 0001", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'b0000;
    next_cycle();
    @(negedge clk);
    n_total++; if (rsp_valid !== 4'b0001) $display("FAIL wrap_rsp_valid: got %b want 0001", rsp_valid); else n_pass++;
    n_total++; if (rsp_sum !== 32'h0000_0001) $display("FAIL wrap_rsp_sum: got %h want 00000001", rsp_sum); else n_pass++;
  endtask

  task automatic test_drain;
    logic [3:0] exp_rdy [8];
    logic [3:0] exp_rsp [8];
    logic       exp_en  [8];
    exp_en  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    exp_rsp = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
    do_reset();
    set_rr_ops();
    for (int c = 0; c < 8; c++) begin
      en        = exp_en[c];
      req_valid = (c < 6) ? 4'hF : 4'h0;
      @(negedge clk);
      n_total++;
      if (req_ready !== exp_rdy[c]) $display("FAIL drain_ready c%0d: got %b want %b", c, req_ready, exp_rdy[c]);
      else n_pass++;
      n_total++;
      if (rsp_valid !== exp_rsp[c]) $display("FAIL drain_rsp c%0d: got %b want %b", c, rsp_valid, exp_rsp[c]);
      else n_pass++;
      if (c == 4) begin
        n_total++; if (busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", busy); else n_pass++;
      end
      if (c == 7) begin
        n_total++; if (rsp_sum !== 32'd133) $display("FAIL drain_rsp_sum: got %0d want 133", rsp_sum); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    en = 1'b1;
    set_rr_ops();
    req_valid = 4'b0110;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0010) $display("FAIL mid_ready0: got %b want 0010", req_ready); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0100) $display("FAIL mid_ready1: got %b want 0100", req_ready); else n_pass++;
    next_cycle();
    nreset    = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_rst_rsp: got %b want 0000", rsp_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", req_ready); else n_pass++;
    n_total++; if (add_a !== 32'd0) $display("FAIL mid_rst_add_a: got %h want 0", add_a); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    req_valid = 4'h0;
    @(negedge clk);
    nreset = 1'b1;
    next_cycle();
    req_valid = 4'hF;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_stale_rsp0: got %b want 0000", rsp_valid); else n_pass++;
    next_cycle();
    req_valid = 4'h0;
    @(negedge clk);
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_stale_rsp1: got %b want 0000", rsp_valid); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (rsp_valid !== 4'b0001) $display("FAIL mid_new_rsp: got %b want 0001", rsp_valid); else n_pass++;
    n_total++; if (rsp_sum !== 32'd100) $display("FAIL mid_new_sum: got %0d want 100", rsp_sum); else n_pass++;
  endtask

`ifdef ADD_SCHED_STATS_EN
  task automatic test_stats;
    do_reset();
    en = 1'b1;
    set_rr_ops();
    req_valid = 4'b0010;
    repeat (5) next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    n_total++; if (stat_grants[31:16] !== 16'd5) $display("FAIL stats_count: got %0d want 5", stat_grants[31:16]); else n_pass++;
    n_total++; if (stat_grants[15:0] !== 16'd0) $display("FAIL stats_other: got %0d want 0", stat_grants[15:0]); else n_pass++;
    next_cycle();
    req_valid = 4'b0010;
    stat_clr  = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0010) $display("FAIL stats_clr_grant: got %b want 0010", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'b0000;
    stat_clr  = 1'b0;
    @(negedge clk);
    n_total++; if (stat_grants[31:16] !== 16'd0) $display("FAIL stats_clr: got %0d want 0", stat_grants[31:16]); else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    nreset  = 1'b0;
    en      = 1'b0;
    req_valid = '0;
    req_a   = '0;
    req_b   = '0;
    mdl_a_q = '0;
    mdl_b_q = '0;
`ifdef ADD_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_single_op();
    test_round_robin();
    test_wrap();
    test_drain();
    test_reset_midflight();
`ifdef ADD_SCHED_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
